// File: rtl/sica_stream_rx.sv
// sica_stream_rx: buffers one channel-major frame in per-channel banks and replays it sample-major.
// Optional per-channel sign-extended running sums on ch_sum: define SICA_RX_CHSUM_EN.
module sica_stream_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int SAMPLES    = 1024,
    parameter int DIM        = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [DATA_WIDTH-1:0]              serial_z_in,
    output logic                               in_ready,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DIM*DATA_WIDTH-1:0]          z_vec,
    output logic [$clog2(SAMPLES)-1:0]         out_index,
    output logic                               frame_done
`ifdef SICA_RX_CHSUM_EN
    ,
    output logic [DIM*(DATA_WIDTH+$clog2(SAMPLES))-1:0] ch_sum
`endif
);
    localparam int IW = $clog2(SAMPLES);
    localparam int CW = $clog2(DIM);
    localparam int SW = DATA_WIDTH + IW;
    localparam logic [IW-1:0] LAST_S = IW'(SAMPLES - 1);
    localparam logic [CW-1:0] LAST_C = CW'(DIM - 1);

    typedef enum logic {LOAD, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             ch_cnt_q, ch_cnt_d;
    logic [IW-1:0]             smp_cnt_q, smp_cnt_d, rd_cnt_q, rd_cnt_d, out_index_q, out_index_d;
    logic                      out_valid_q, out_valid_d, frame_done_q, frame_done_d;
    logic [DIM*DATA_WIDTH-1:0] z_vec_q, z_vec_d, rd_vec;
    logic [DATA_WIDTH-1:0]     bank [DIM][SAMPLES];
    logic                      wr_en, last_word, last_out, issue;

    assign in_ready  = state_q == LOAD;
    assign wr_en     = in_valid && in_ready;
    assign last_word = wr_en && ch_cnt_q == LAST_C && smp_cnt_q == LAST_S;
    assign last_out  = out_valid_q && out_index_q == LAST_S;

    always_ff @(posedge clk)
        if (wr_en) bank[ch_cnt_q][smp_cnt_q] <= serial_z_in;

    always_comb
        for (int k = 0; k < DIM; k++) rd_vec[k*DATA_WIDTH +: DATA_WIDTH] = bank[k][rd_cnt_q];

    // Vector 0 is issued on the same edge as the last write so the drain takes exactly SAMPLES cycles.
    always_comb begin
        state_d      = state_q;
        ch_cnt_d     = ch_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        out_index_d  = out_index_q;
        out_valid_d  = out_valid_q;
        z_vec_d      = z_vec_q;
        frame_done_d = 1'b0;
        issue        = 1'b0;
        if (state_q == LOAD) begin
            if (wr_en) begin
                smp_cnt_d = smp_cnt_q + 1'b1;
                if (smp_cnt_q == LAST_S) ch_cnt_d = ch_cnt_q + 1'b1;
            end
            if (last_word) begin
                state_d  = DRAIN;
                ch_cnt_d = '0;
                issue    = 1'b1;
            end
        end else if (last_out && out_ready) begin
            state_d      = LOAD;
            out_valid_d  = 1'b0;
            frame_done_d = 1'b1;
            rd_cnt_d     = '0;
        end else if (!last_out && (!out_valid_q || out_ready)) begin
            issue = 1'b1;
        end
        if (issue) begin
            z_vec_d     = rd_vec;
            out_index_d = rd_cnt_q;
            out_valid_d = 1'b1;
            rd_cnt_d    = rd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            ch_cnt_q     <= '0;
            smp_cnt_q    <= '0;
            rd_cnt_q     <= '0;
            out_index_q  <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            z_vec_q      <= '0;
        end else begin
            state_q      <= state_d;
            ch_cnt_q     <= ch_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            out_index_q  <= out_index_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            z_vec_q      <= z_vec_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign z_vec      = z_vec_q;
    assign out_index  = out_index_q;
    assign frame_done = frame_done_q;

`ifdef SICA_RX_CHSUM_EN
    logic [DIM*SW-1:0] ch_sum_q, ch_sum_d;

    // Sums clear together with the frame_done pulse, ready for the next frame.
    always_comb begin
        ch_sum_d = frame_done_d ? '0 : ch_sum_q;
        if (wr_en)
            ch_sum_d[ch_cnt_q*SW +: SW] = ch_sum_q[ch_cnt_q*SW +: SW] +
                                          {{IW{serial_z_in[DATA_WIDTH-1]}}, serial_z_in};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ch_sum_q <= '0;
        else        ch_sum_q <= ch_sum_d;

    assign ch_sum = ch_sum_q;
`endif
endmodule

// File: tb/tb_sica_stream_rx.sv
// tb_sica_stream_rx: randomized frames checked against a channel-major to sample-major reference.
// Define SICA_RX_CHSUM_EN to also check ch_sum.
module tb_sica_stream_rx;
    localparam int DW = 32;
    localparam int S  = 8;
    localparam int D  = 3;
    localparam int IW = $clog2(S);
    localparam int SW = DW + IW;

    logic            clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0]   serial_z_in = '0;
    logic            in_ready, out_valid, frame_done;
    logic [D*DW-1:0] z_vec;
    logic [IW-1:0]   out_index;
`ifdef SICA_RX_CHSUM_EN
    logic [D*SW-1:0] ch_sum;
`endif

    int errors = 0, checks = 0;
    logic [DW-1:0] frame [D*S];

    always #5 clk = ~clk;

    sica_stream_rx #(.DATA_WIDTH(DW), .SAMPLES(S), .DIM(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .serial_z_in(serial_z_in),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .z_vec(z_vec), .out_index(out_index), .frame_done(frame_done)
`ifdef SICA_RX_CHSUM_EN
        , .ch_sum(ch_sum)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D*DW-1:0] exp_vec(input int n);
        logic [D*DW-1:0] r;
        for (int k = 0; k < D; k++) r[k*DW +: DW] = frame[k*S + n];
        return r;
    endfunction

    function automatic logic [D*SW-1:0] exp_sum();
        logic [D*SW-1:0] r = '0;
        for (int k = 0; k < D; k++)
            for (int n = 0; n < S; n++)
                r[k*SW +: SW] = r[k*SW +: SW] + SW'($signed(frame[k*S + n]));
        return r;
    endfunction

    task automatic ramp();
        for (int i = 0; i < D*S; i++) frame[i] = DW'(100 * (i / S) + i % S);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < D*S; i++) frame[i] = $urandom;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_z_vec"}, z_vec, 0);
        check({tag, "_out_index"}, out_index, 0);
        check({tag, "_frame_done"}, frame_done, 0);
`ifdef SICA_RX_CHSUM_EN
        check({tag, "_ch_sum"}, ch_sum, 0);
`endif
    endtask

    // gap < 0 toggles in_valid 1010..., otherwise gap is the percent chance of an idle beat.
    task automatic load_frame(input int gap, input int stop_after);
        int i = 0, guard = 0;
        while (i < D*S && i != stop_after && guard < 2000) begin
            in_valid    = gap < 0 ? (guard % 2 == 0) : ($urandom_range(99) >= gap);
            serial_z_in = in_valid ? frame[i] : $urandom;
            guard++;
            @(negedge clk);
            check("load_in_ready", in_ready, 1);
            check("load_out_valid", out_valid, 0);
            @(posedge clk); #1;
            if (in_valid) i++;
        end
        check("load_count", i, stop_after < 0 ? D*S : stop_after);
        in_valid = 1'b0;
    endtask

    // bp: 0 always ready, 1 random ready, 2 stall 5 cycles on vector 3.
    task automatic drain_frame(input int bp);
        int n = 0, hold = 0, guard = 0;
        logic v;
        while (n < S && guard < 400) begin
            guard++;
            in_valid    = 1'($urandom_range(1));
            serial_z_in = $urandom;
            out_ready   = bp == 0 ? 1'b1 : bp == 1 ? 1'($urandom_range(1)) : !(n == 3 && hold < 5);
            if (bp == 2 && n == 3 && hold < 5) hold++;
            @(negedge clk);
            v = out_valid;
            check("drain_in_ready", in_ready, 0);
            check("drain_out_valid", out_valid, 1);
            check("drain_frame_done", frame_done, 0);
            check($sformatf("out_index_%0d", n), out_index, n);
            check($sformatf("z_vec_%0d", n), z_vec, exp_vec(n));
`ifdef SICA_RX_CHSUM_EN
            check("drain_ch_sum", ch_sum, exp_sum());
`endif
            @(posedge clk); #1;
            if (v && out_ready) n++;
        end
        check("drain_count", n, S);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", frame_done, 1);
        check("done_out_valid", out_valid, 0);
        check("done_in_ready", in_ready, 1);
`ifdef SICA_RX_CHSUM_EN
        check("done_ch_sum", ch_sum, 0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check("done_once", frame_done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        ramp(); load_frame(0, -1);  drain_frame(0);
        ramp(); load_frame(-1, -1); drain_frame(0);
        ramp(); load_frame(0, -1);  drain_frame(2);

        rand_frame();
        frame[1]       = 32'h8000_0000;
        frame[S + 2]   = 32'h7FFF_FFFF;
        frame[2*S + 7] = 32'hFFFF_FFFF;
        load_frame(30, -1); drain_frame(1);

        rand_frame(); load_frame(0, 11);
        rst_n = 1'b0; #1;
        reset_checks("mid_load_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ramp(); load_frame(0, -1); drain_frame(0);

        rand_frame(); load_frame(0, -1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0; #1;
        reset_checks("mid_drain_reset");
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b0;
        ramp(); load_frame(20, -1); drain_frame(0);

        repeat (4) begin
            rand_frame(); load_frame($urandom_range(60), -1); drain_frame(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sica_stream_rx.md
Name: sica_stream_rx

Overview:
- Receiving end of the serial mixed-signal stream (`serial_z_in`) that carries one frame of DIM channels × SAMPLES words, channel-major, one word per accepted beat.
- Buffers a full frame in DIM per-channel banks, then replays it sample-major: one DIM-wide observation vector per handshake, for the whitening/FastICA core.
- Alternates between LOAD and DRAIN. Frames are back-to-back with no software involvement.

Parameters:
- DATA_WIDTH, 32, signed sample width.
- SAMPLES, 1024, samples per channel per frame; power of two, ≥ 2.
- DIM, 5, number of channels; ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  `serial_z_in` carries a word.
- serial_z_in  in  DATA_WIDTH  signed input word, channel-major order.
- in_ready  out  1  block accepts a word this cycle.
- out_valid  out  1  `z_vec` holds a valid vector.
- out_ready  in  1  downstream accepts `z_vec`.
- z_vec  out  DIM*DATA_WIDTH  channel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_index  out  $clog2(SAMPLES)  sample index of `z_vec`.
- frame_done  out  1  one-cycle pulse after the last vector of a frame is taken.

Behaviour:
- Reset (async assert, sync release): state=LOAD; ch_cnt=0, smp_cnt=0, rd_cnt=0; in_ready=1, out_valid=0, z_vec=0, out_index=0, frame_done=0. Bank contents are not reset.
- Counters: ch_cnt [0..DIM-1], smp_cnt and rd_cnt [0..SAMPLES-1].
- LOAD:
  - in_ready=1 combinationally.
  - On in_valid&&in_ready, write bank[ch_cnt][smp_cnt] = `serial_z_in`.
  - smp_cnt++; at SAMPLES-1 it wraps to 0 and ch_cnt++.
  - in_valid=0 cycles are gaps; counters hold.
- LOAD→DRAIN: on acceptance of the word at ch_cnt=DIM-1, smp_cnt=SAMPLES-1.
  - ch_cnt and smp_cnt clear to 0.
  - in_ready=0 from the next cycle. No input accepted in DRAIN; `serial_z_in` is ignored.
- DRAIN:
  - Output is a registered stage. When out_valid=0, or out_valid&&out_ready, and vectors remain, load z_vec[k]=bank[k][rd_cnt] for all k, set out_index=rd_cnt, out_valid=1, rd_cnt++.
  - out_valid first rises the 1st cycle after entering DRAIN.
  - Under continuous out_ready, one vector is issued per cycle.
  - z_vec and out_index hold stable while out_valid&&!out_ready.
- DRAIN→LOAD: on the handshake of the vector with out_index=SAMPLES-1.
  - frame_done=1 for exactly that next cycle; out_valid=0; rd_cnt=0.
  - State=LOAD, so in_ready=1 in the same cycle as frame_done.
- Frame latency:
  - First vector is valid 1 cycle after the last input word is accepted.
  - Full drain takes SAMPLES cycles with no backpressure.
- Reset mid-operation (either state): partial frame discarded, outputs return to reset values immediately, and the next accepted word is treated as ch 0, sample 0.
- Values pass through unmodified (no rounding, no sign change). Negative values are preserved bit-exact.

Optional Feature:
- Macro: SICA_RX_CHSUM_EN.
- When defined:
  - Adds output `ch_sum`, width DIM*(DATA_WIDTH+$clog2(SAMPLES)), one signed accumulator per channel, channel k in slice k.
  - During LOAD, each accepted word is sign-extended and added to accumulator[ch_cnt].
  - All accumulators clear on reset and on the cycle frame_done pulses.
  - `ch_sum` is stable and valid throughout DRAIN, for downstream centering.
- When undefined: no `ch_sum` port and no accumulator logic; all other behaviour is identical.

Test Plan:
- Ramp, DIM=3, SAMPLES=8: input word = 100*ch+smp, in_valid held high, out_ready=1 → 8 consecutive vectors. Vector n = {200+n, 100+n, n}, out_index=n. frame_done pulses 1 cycle after vector 7. in_ready=0 for exactly 8 cycles.
- Input gaps: in_valid toggling 1010… over the same ramp → identical output sequence. Transition to DRAIN only after the 24th accepted word.
- Backpressure: out_ready low for 5 cycles while vector 3 is valid → z_vec = {203, 103, 3} and out_index=3 held stable. No vector skipped or duplicated.
- Negative/extreme values: words 0x80000000, 0x7FFFFFFF, -1 → reproduced bit-exact at their sample-major positions.
- Reset mid-load: rst_n pulsed low after 11 accepted words, then a full ramp → outputs match the clean ramp case. No stale data appears.
- With SICA_RX_CHSUM_EN: ramp as in the first scenario → `ch_sum` = {1628, 828, 28} throughout DRAIN. It reads 0 in the cycle after frame_done.
